b_format_uop_decoder: RTL and testbench
=======================================

Name: b_format_uop_decoder

Overview:
- Parametrised successor to the single-shot B-form decoder in the decode stage.
- Decodes B-form conditional branches (bc/bca/bcl/bcla, primary opcode 16).
- Cracks each branch into 1–3 micro-ops: optional CTR decrement, branch, optional link write.
- Computes the branch target and buffers micro-ops in a QueueDepth-entry output queue with stall back-pressure toward issue.

Parameters:
addressWidth, 64, instruction/target address width
instructionWidth, 32, instruction width
PidSize, 20, process ID width
TidSize, 16, thread ID width
instructionCounterWidth, 64, major ID width
instMinIdWidth, 7, minor ID width
opcodeSize, 12, decoded opcode width
regSize, 5, register field width
immediateSize, 14, BD field width
funcUnitCodeSize, 3, functional unit code width
BranchUnitID, 6, functional unit code for all emitted micro-ops
B, 2, instFormat_i value selecting B-form
QueueDepth, 4, output queue entries (power of two, ≥2)

Ports:
clock_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
enable_i  in  1  input instruction valid
stall_i  in  1  downstream stall; holds queue head
instFormat_i  in  26  format code; accepted only when == B
instructionOpcode_i  in  6  primary opcode
instruction_i  in  instructionWidth  raw instruction
instructionAddress_i  in  addressWidth  CIA
is64Bit_i  in  1  64-bit mode
instructionPid_i  in  PidSize  process ID
instructionTid_i  in  TidSize  thread ID
instructionMajId_i  in  instructionCounterWidth  major ID
busy_o  out  1  input not accepted this cycle
enable_o  out  1  queue head valid and not stalled
opcode_o  out  opcodeSize  1 = BRANCH, 2 = LINK, 3 = CTRDEC
instructionAddress_o  out  addressWidth  CIA of parent instruction
branchTarget_o  out  addressWidth  BRANCH: target; LINK: CIA+4; CTRDEC: 0
functionalUnitType_o  out  funcUnitCodeSize  BranchUnitID
instMajId_o  out  instructionCounterWidth  copied from input
instMinId_o  out  instMinIdWidth  micro-op index within instruction
is64Bit_o  out  1  copied from input
instPid_o  out  PidSize  copied from input
instTid_o  out  TidSize  copied from input
instructionBody_o  out  2*regSize+immediateSize+4  {BO, BI, BD, AA, LK, 2'b00}

Behaviour:
- Instruction fields (bit 0 = MSB): opcode[0:5], BO[6:10], BI[11:15], BD[16:29], AA[30], LK[31].
- Accept condition: enable_i && !busy_o && instFormat_i == B && instructionOpcode_i == 16.
- Ignored inputs: enable_i with any other format or opcode is dropped, no queue effect. Input presented while busy_o is high is dropped; the sender must hold it.
- Micro-op sequence per instruction, minor IDs consecutive from 0:
  - CTRDEC, emitted only if BO[2] == 0.
  - BRANCH, always emitted.
  - LINK, emitted only if LK == 1.
- Target: ext = sign-extend({BD, 2'b00}) to addressWidth.
  - AA = 1: target = ext.
  - AA = 0: target = CIA + ext, modulo 2^addressWidth.
  - is64Bit_i == 0: target and CIA+4 have the upper 32 bits forced to 0.
- Sequencer FSM:
  - IDLE: on accept, push the first micro-op the same edge. Go to EMIT if more micro-ops remain, else stay IDLE.
  - EMIT: push the next micro-op on each edge where a slot is free. Return to IDLE after the last push.
  - Latched instruction fields hold throughout EMIT.
- busy_o = (state != IDLE) || (count == QueueDepth).
- Queue:
  - Pop when count > 0 && !stall_i.
  - Push allowed when count < QueueDepth, or when a pop occurs the same cycle (full + pop + push keeps count constant).
  - Pointers wrap modulo QueueDepth.
- Outputs are driven from the queue head. enable_o = (count > 0) && !stall_i. Other outputs hold head values and are undefined-but-stable when empty.
- Latency: accept at edge N → first micro-op visible at enable_o after edge N when not stalled.
- Reset (asynchronous, including mid-EMIT): state IDLE, count 0, pointers 0, all micro-ops in flight discarded. All outputs 0, enable_o 0, busy_o 0.

Optional Feature:
- B_DECODE_ILLEGAL_TRAP_EN defined: a B-format input with opcode != 16 is accepted and pushes one micro-op: opcode_o = 12'hFFF, minor ID 0, target 0, body = raw instruction bits [6:31] with 2'b00 appended.
- Undefined: such inputs are silently dropped.

Test Plan:
- BO=10100, BI=0, BD=14'h0010, AA=0, LK=0, CIA=0x1000, is64Bit=1 → one micro-op: opcode 1, minId 0, target 0x1040, busy_o never asserted.
- BO=00000, LK=1, AA=0, BD=14'h0010, CIA=0x1000 → three micro-ops on consecutive cycles:
  - opcode 3 / minId 0
  - opcode 1 / minId 1, target 0x1040
  - opcode 2 / minId 2, target 0x1004
  - busy_o high for 2 cycles.
- AA=1, BD=14'h3FFF: is64Bit=1 → target 0xFFFFFFFFFFFFFFFC; is64Bit=0 → 0x00000000FFFFFFFC.
- stall_i held high while 4 single-micro-op branches are sent → count reaches 4, busy_o=1, 5th input dropped. Release stall → 4 micro-ops emitted in order, enable_o high 4 cycles.
- reset_i pulsed mid-EMIT of a 3-micro-op branch → enable_o and busy_o 0 immediately. No further micro-ops after release.
- instFormat_i=4 or opcode=18 with enable_i=1 → no micro-op (without the macro); opcode_o=12'hFFF (with B_DECODE_ILLEGAL_TRAP_EN, format B, opcode 18).

Source files
------------

// File: rtl/b_format_uop_decoder_if.sv
// Issue-side bundle for the B-form micro-op decoder: instruction in, cracked micro-ops out.
// slave = decoder side, master = the driver/consumer side.
interface b_format_uop_decoder_if #(
  parameter int addressWidth            = 64,
  parameter int instructionWidth        = 32,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64,
  parameter int instMinIdWidth          = 7,
  parameter int opcodeSize              = 12,
  parameter int regSize                 = 5,
  parameter int immediateSize           = 14,
  parameter int funcUnitCodeSize        = 3
);
  logic                                      enable_i;
  logic                                      stall_i;
  logic [25:0]                               instFormat_i;
  logic [5:0]                                instructionOpcode_i;
  logic [instructionWidth-1:0]               instruction_i;
  logic [addressWidth-1:0]                   instructionAddress_i;
  logic                                      is64Bit_i;
  logic [PidSize-1:0]                        instructionPid_i;
  logic [TidSize-1:0]                        instructionTid_i;
  logic [instructionCounterWidth-1:0]        instructionMajId_i;

  logic                                      busy_o;
  logic                                      enable_o;
  logic [opcodeSize-1:0]                     opcode_o;
  logic [addressWidth-1:0]                   instructionAddress_o;
  logic [addressWidth-1:0]                   branchTarget_o;
  logic [funcUnitCodeSize-1:0]               functionalUnitType_o;
  logic [instructionCounterWidth-1:0]        instMajId_o;
  logic [instMinIdWidth-1:0]                 instMinId_o;
  logic                                      is64Bit_o;
  logic [PidSize-1:0]                        instPid_o;
  logic [TidSize-1:0]                        instTid_o;
  logic [2*regSize+immediateSize+4-1:0]      instructionBody_o;

  modport slave (
    input  enable_i, stall_i, instFormat_i, instructionOpcode_i, instruction_i,
           instructionAddress_i, is64Bit_i, instructionPid_i, instructionTid_i, instructionMajId_i,
    output busy_o, enable_o, opcode_o, instructionAddress_o, branchTarget_o, functionalUnitType_o,
           instMajId_o, instMinId_o, is64Bit_o, instPid_o, instTid_o, instructionBody_o
  );

  modport master (
    output enable_i, stall_i, instFormat_i, instructionOpcode_i, instruction_i,
           instructionAddress_i, is64Bit_i, instructionPid_i, instructionTid_i, instructionMajId_i,
    input  busy_o, enable_o, opcode_o, instructionAddress_o, branchTarget_o, functionalUnitType_o,
           instMajId_o, instMinId_o, is64Bit_o, instPid_o, instTid_o, instructionBody_o
  );
endinterface

// File: rtl/b_format_uop_decoder.sv
// Cracks B-form branches (opcode 16) into CTRDEC/BRANCH/LINK micro-ops behind a small output queue.
// Optional: define B_DECODE_ILLEGAL_TRAP_EN to turn B-format inputs with other opcodes into a trap micro-op.
module b_format_uop_decoder #(
  parameter int addressWidth            = 64,
  parameter int instructionWidth        = 32,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64,
  parameter int instMinIdWidth          = 7,
  parameter int opcodeSize              = 12,
  parameter int regSize                 = 5,
  parameter int immediateSize           = 14,
  parameter int funcUnitCodeSize        = 3,
  parameter int BranchUnitID            = 6,
  parameter int B                       = 2,
  parameter int QueueDepth              = 4
) (
  input logic clock_i,
  input logic reset_i,
  b_format_uop_decoder_if.slave bus
);
  localparam int BW = 2*regSize+immediateSize+4;
  localparam int PW = $clog2(QueueDepth);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(QueueDepth);
  localparam logic [opcodeSize-1:0] OP_BR   = opcodeSize'(1);
  localparam logic [opcodeSize-1:0] OP_LINK = opcodeSize'(2);
  localparam logic [opcodeSize-1:0] OP_CTR  = opcodeSize'(3);

  typedef struct packed {
    logic [opcodeSize-1:0]              op;
    logic [addressWidth-1:0]            cia;
    logic [addressWidth-1:0]            tgt;
    logic [funcUnitCodeSize-1:0]        fu;
    logic [instructionCounterWidth-1:0] maj;
    logic [instMinIdWidth-1:0]          mn;
    logic                               is64;
    logic [PidSize-1:0]                 pid;
    logic [TidSize-1:0]                 tid;
    logic [BW-1:0]                      body;
  } uop_t;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                             state;
  logic [CW-1:0]                      count;
  logic [PW-1:0]                      rd_ptr, wr_ptr;
  uop_t                               q [QueueDepth];
  logic [1:0]                         nxt;
  logic [25:0]                        l_inst;
  logic [addressWidth-1:0]            l_cia;
  logic                               l_is64;
  logic [PidSize-1:0]                 l_pid;
  logic [TidSize-1:0]                 l_tid;
  logic [instructionCounterWidth-1:0] l_maj;

  logic idle, busy, decodable, accept, trap, pop, room, push, last;
  assign idle      = (state == IDLE);
  assign busy      = !idle || (count == FULL);
  assign decodable = bus.enable_i && !busy && (bus.instFormat_i == 26'(B));
  assign accept    = decodable && (bus.instructionOpcode_i == 6'd16);
`ifdef B_DECODE_ILLEGAL_TRAP_EN
  assign trap      = decodable && (bus.instructionOpcode_i != 6'd16);
`else
  assign trap      = 1'b0;
`endif
  assign pop  = (count != '0) && !bus.stall_i;
  assign room = (count != FULL) || pop;

  // In IDLE the first micro-op is built straight from the inputs; EMIT uses the latched copy.
  logic [25:0]                        s_inst;
  logic [addressWidth-1:0]            s_cia;
  logic                               s_is64;
  assign s_inst = idle ? bus.instruction_i[25:0] : l_inst;
  assign s_cia  = idle ? bus.instructionAddress_i : l_cia;
  assign s_is64 = idle ? bus.is64Bit_i : l_is64;

  logic unused_bits;
  assign unused_bits = ^bus.instruction_i[instructionWidth-1:26];

  logic                    has_ctr, lk, aa;
  logic [13:0]             bd;
  logic [1:0]              n_uops, idx;
  logic [addressWidth-1:0] ext, lo_mask, br_tgt, link_tgt;
  assign has_ctr  = !s_inst[23];
  assign lk       = s_inst[0];
  assign aa       = s_inst[1];
  assign bd       = s_inst[15:2];
  assign n_uops   = 2'd1 + {1'b0, has_ctr} + {1'b0, lk};
  assign idx      = idle ? 2'd0 : nxt;
  assign last     = (idx == n_uops - 2'd1);
  assign ext      = {{(addressWidth-16){bd[13]}}, bd, 2'b00};
  assign lo_mask  = s_is64 ? '1 : addressWidth'(32'hFFFF_FFFF);
  assign br_tgt   = (aa ? ext : s_cia + ext) & lo_mask;
  assign link_tgt = (s_cia + addressWidth'(4)) & lo_mask;
  assign push     = idle ? (accept || trap) : room;

  uop_t u;
  always_comb begin
    u      = '0;
    u.cia  = s_cia;
    u.fu   = funcUnitCodeSize'(BranchUnitID);
    u.maj  = idle ? bus.instructionMajId_i : l_maj;
    u.mn   = instMinIdWidth'(idx);
    u.is64 = s_is64;
    u.pid  = idle ? bus.instructionPid_i : l_pid;
    u.tid  = idle ? bus.instructionTid_i : l_tid;
    u.body = BW'({s_inst, 2'b00});
    if (has_ctr && idx == 2'd0) begin
      u.op = OP_CTR;
    end else if (idx == {1'b0, has_ctr}) begin
      u.op  = OP_BR;
      u.tgt = br_tgt;
    end else begin
      u.op  = OP_LINK;
      u.tgt = link_tgt;
    end
    if (trap) begin
      u.op  = '1;
      u.tgt = '0;
      u.mn  = '0;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state  <= IDLE;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      nxt    <= '0;
      l_inst <= '0;
      l_cia  <= '0;
      l_is64 <= 1'b0;
      l_pid  <= '0;
      l_tid  <= '0;
      l_maj  <= '0;
      for (int i = 0; i < QueueDepth; i++) q[i] <= '0;
    end else begin
      if (push) begin
        q[wr_ptr] <= u;
        wr_ptr    <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      case (state)
        IDLE: if (accept) begin
          l_inst <= bus.instruction_i[25:0];
          l_cia  <= bus.instructionAddress_i;
          l_is64 <= bus.is64Bit_i;
          l_pid  <= bus.instructionPid_i;
          l_tid  <= bus.instructionTid_i;
          l_maj  <= bus.instructionMajId_i;
          nxt    <= 2'd1;
          if (n_uops > 2'd1) state <= EMIT;
        end
        EMIT: if (room) begin
          nxt <= nxt + 2'd1;
          if (last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  uop_t head;
  assign head = q[rd_ptr];
  assign bus.busy_o               = busy;
  assign bus.enable_o             = (count != '0) && !bus.stall_i;
  assign bus.opcode_o             = head.op;
  assign bus.instructionAddress_o = head.cia;
  assign bus.branchTarget_o       = head.tgt;
  assign bus.functionalUnitType_o = head.fu;
  assign bus.instMajId_o          = head.maj;
  assign bus.instMinId_o          = head.mn;
  assign bus.is64Bit_o            = head.is64;
  assign bus.instPid_o            = head.pid;
  assign bus.instTid_o            = head.tid;
  assign bus.instructionBody_o    = head.body;
endmodule

// File: tb/tb_b_format_uop_decoder.sv
// Directed bench for b_format_uop_decoder: a micro-op expansion model feeds an expected queue
// that a negedge monitor drains, plus hand-computed literal checks.
module tb_b_format_uop_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  b_format_uop_decoder_if bus ();
  b_format_uop_decoder dut (.clock_i(clk), .reset_i(rst), .bus(bus));

  typedef struct packed {
    logic [11:0] op;
    logic [63:0] cia;
    logic [63:0] tgt;
    logic [6:0]  mn;
    logic [63:0] maj;
    logic        is64;
    logic [19:0] pid;
    logic [15:0] tid;
    logic [27:0] body;
  } exp_t;

  exp_t expq[$];
  exp_t seen[$];
  int errors = 0;
  int checks = 0;
  longint unsigned maj_ctr = 100;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mk(logic [4:0] bo, logic [4:0] bi, logic [13:0] bd, logic aa, logic lk);
    return {6'd16, bo, bi, bd, aa, lk};
  endfunction

  // Expected micro-op stream for one accepted branch, straight from the cracking rules.
  function automatic void expand(logic [31:0] ins, logic [63:0] cia, logic is64,
                                 logic [19:0] pid, logic [15:0] tid, logic [63:0] maj);
    logic signed [13:0] sbd;
    longint ext, tgt, link;
    int mn;
    exp_t e;
    sbd  = ins[15:2];
    ext  = sbd;
    ext  = ext * 4;
    tgt  = ins[1] ? ext : longint'(cia) + ext;
    link = longint'(cia) + 4;
    if (!is64) begin
      tgt  = tgt & 64'hFFFF_FFFF;
      link = link & 64'hFFFF_FFFF;
    end
    mn = 0;
    e.cia = cia; e.maj = maj; e.is64 = is64; e.pid = pid; e.tid = tid;
    e.body = {ins[25:0], 2'b00};
    if (ins[23] == 1'b0) begin
      e.op = 12'd3; e.tgt = 64'd0; e.mn = 7'(mn); mn++;
      expq.push_back(e);
    end
    e.op = 12'd1; e.tgt = tgt; e.mn = 7'(mn); mn++;
    expq.push_back(e);
    if (ins[0]) begin
      e.op = 12'd2; e.tgt = link; e.mn = 7'(mn);
      expq.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    exp_t a, e;
    if (!rst && bus.enable_o) begin
      a.op = bus.opcode_o; a.cia = bus.instructionAddress_o; a.tgt = bus.branchTarget_o;
      a.mn = bus.instMinId_o; a.maj = bus.instMajId_o; a.is64 = bus.is64Bit_o;
      a.pid = bus.instPid_o; a.tid = bus.instTid_o; a.body = bus.instructionBody_o;
      seen.push_back(a);
      chk("fu_type", 64'(bus.functionalUnitType_o), 64'd6);
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_uop: got %h, required none", a);
      end else begin
        e = expq.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL uop_stream: got %h, required %h", a, e);
        end
      end
    end
  end

  // Present one input for a single cycle; optionally wait (bounded) for busy_o low first.
  task automatic present(logic [25:0] fmt, logic [5:0] opc, logic [31:0] ins, logic [63:0] cia,
                         logic is64, bit wait_free, bit model_accept, bit trap_uop);
    logic [19:0] pid;
    logic [15:0] tid;
    exp_t e;
    int n;
    if (wait_free) begin
      n = 0;
      while (bus.busy_o && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) begin checks++; errors++; $display("FAIL busy_timeout: got busy, required idle"); end
    end
    maj_ctr++;
    pid = 20'(maj_ctr * 3);
    tid = 16'(maj_ctr * 7);
    bus.enable_i = 1'b1; bus.instFormat_i = fmt; bus.instructionOpcode_i = opc;
    bus.instruction_i = ins; bus.instructionAddress_i = cia; bus.is64Bit_i = is64;
    bus.instructionPid_i = pid; bus.instructionTid_i = tid; bus.instructionMajId_i = maj_ctr;
    if (model_accept) expand(ins, cia, is64, pid, tid, maj_ctr);
    if (trap_uop) begin
      e.op = 12'hFFF; e.cia = cia; e.tgt = 64'd0; e.mn = 7'd0; e.maj = maj_ctr;
      e.is64 = is64; e.pid = pid; e.tid = tid; e.body = {ins[25:0], 2'b00};
      expq.push_back(e);
    end
    @(posedge clk); #1;
    bus.enable_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 60) begin @(posedge clk); #1; n++; end
    chk("drain_left", 64'(expq.size()), 64'd0);
  endtask

  task automatic idle_cycles(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int base;
    logic [7:0] pat;
    bus.enable_i = 0; bus.stall_i = 0; bus.instFormat_i = 0; bus.instructionOpcode_i = 0;
    bus.instruction_i = 0; bus.instructionAddress_i = 0; bus.is64Bit_i = 0;
    bus.instructionPid_i = 0; bus.instructionTid_i = 0; bus.instructionMajId_i = 0;
    #12;
    chk("reset_enable_o", 64'(bus.enable_o), 0);
    chk("reset_busy_o", 64'(bus.busy_o), 0);
    chk("reset_opcode_o", 64'(bus.opcode_o), 0);
    chk("reset_target_o", bus.branchTarget_o, 0);
    @(posedge clk); #1; rst = 0;
    idle_cycles(2);

    // single BRANCH, visible right after the accepting edge
    base = seen.size();
    present(26'd2, 6'd16, mk(5'b10100, 5'd0, 14'h0010, 1'b0, 1'b0), 64'h1000, 1'b1, 1, 1, 0);
    chk("t1_latency_enable", 64'(bus.enable_o), 1);
    chk("t1_busy", 64'(bus.busy_o), 0);
    drain();
    chk("t1_count", 64'(seen.size() - base), 1);
    chk("t1_op", 64'(seen[base].op), 1);
    chk("t1_target", seen[base].tgt, 64'h1040);

    // CTRDEC + BRANCH + LINK, busy for two cycles
    base = seen.size();
    present(26'd2, 6'd16, mk(5'b00000, 5'd3, 14'h0010, 1'b0, 1'b1), 64'h1000, 1'b1, 1, 1, 0);
    chk("t2_busy_c0", 64'(bus.busy_o), 1);
    @(posedge clk); #1;
    chk("t2_busy_c1", 64'(bus.busy_o), 1);
    @(posedge clk); #1;
    chk("t2_busy_c2", 64'(bus.busy_o), 0);
    drain();
    chk("t2_count", 64'(seen.size() - base), 3);
    chk("t2_op0", 64'({seen[base].op, 5'd0, seen[base].mn}), 64'({12'd3, 5'd0, 7'd0}));
    chk("t2_op1", 64'({seen[base+1].op, 5'd0, seen[base+1].mn}), 64'({12'd1, 5'd0, 7'd1}));
    chk("t2_tgt1", seen[base+1].tgt, 64'h1040);
    chk("t2_op2", 64'({seen[base+2].op, 5'd0, seen[base+2].mn}), 64'({12'd2, 5'd0, 7'd2}));
    chk("t2_tgt2", seen[base+2].tgt, 64'h1004);

    // absolute target with maximal negative BD, both modes; relative wrap in 32-bit mode
    base = seen.size();
    present(26'd2, 6'd16, mk(5'b10100, 5'd1, 14'h3FFF, 1'b1, 1'b0), 64'h1000, 1'b1, 1, 1, 0);
    present(26'd2, 6'd16, mk(5'b10100, 5'd1, 14'h3FFF, 1'b1, 1'b0), 64'h1000, 1'b0, 1, 1, 0);
    present(26'd2, 6'd16, mk(5'b10100, 5'd2, 14'h2000, 1'b0, 1'b1), 64'h1_0000_1000, 1'b0, 1, 1, 0);
    drain();
    chk("t3_abs64", seen[base].tgt, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t3_abs32", seen[base+1].tgt, 64'h0000_0000_FFFF_FFFC);
    chk("t3_rel32_link", seen[base+3].tgt, 64'h0000_0000_0000_1004);

    // fill under stall, fifth dropped, then release
    base = seen.size();
    bus.stall_i = 1'b1;
    for (int i = 0; i < 4; i++)
      present(26'd2, 6'd16, mk(5'b10100, 5'(i), 14'h0004, 1'b0, 1'b0), 64'h2000 + 64'(i*16), 1'b1, 1, 1, 0);
    chk("t4_full_busy", 64'(bus.busy_o), 1);
    chk("t4_stalled_enable", 64'(bus.enable_o), 0);
    present(26'd2, 6'd16, mk(5'b10100, 5'd9, 14'h0004, 1'b0, 1'b0), 64'h3000, 1'b1, 0, 0, 0);
    bus.stall_i = 1'b0;
    pat = '0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); pat[i] = bus.enable_o; end
    chk("t4_enable_pattern", 64'(pat), 64'h0F);
    chk("t4_count", 64'(seen.size() - base), 4);
    drain();

    // reset mid-EMIT
    @(posedge clk); #1;
    base = seen.size();
    present(26'd2, 6'd16, mk(5'b00000, 5'd4, 14'h0020, 1'b0, 1'b1), 64'h4000, 1'b1, 1, 1, 0);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("t5_enable_o", 64'(bus.enable_o), 0);
    chk("t5_busy_o", 64'(bus.busy_o), 0);
    chk("t5_opcode_o", 64'(bus.opcode_o), 0);
    expq.delete();
    @(posedge clk); #3; rst = 1'b0;
    base = seen.size();
    idle_cycles(6);
    chk("t5_no_more_uops", 64'(seen.size() - base), 0);

    // non-B format and non-16 opcode
    base = seen.size();
    present(26'd4, 6'd16, mk(5'b10100, 5'd0, 14'h0010, 1'b0, 1'b0), 64'h5000, 1'b1, 1, 0, 0);
`ifdef B_DECODE_ILLEGAL_TRAP_EN
    present(26'd2, 6'd18, mk(5'b10100, 5'd5, 14'h0010, 1'b0, 1'b1), 64'h5000, 1'b1, 1, 0, 1);
    drain();
    chk("t6_trap_count", 64'(seen.size() - base), 1);
    chk("t6_trap_op", 64'(seen[base].op), 64'hFFF);
`else
    present(26'd2, 6'd18, mk(5'b10100, 5'd5, 14'h0010, 1'b0, 1'b1), 64'h5000, 1'b1, 1, 0, 0);
    idle_cycles(4);
    chk("t6_dropped", 64'(seen.size() - base), 0);
`endif

    idle_cycles(3);
    chk("final_expq_empty", 64'(expq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
